// File: rtl/accumulator_bank.sv
// Bank of COLS independent column accumulators (ROWS entries each) that capture
// skewed partial sums and drain them row-major, saturated, to the unified buffer.
module accumulator_bank #(
  parameter int COLS  = 2,
  parameter int ROWS  = 2,
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32,
  parameter int AW    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS-1:0]      col_valid,
  input  logic [COLS*IN_W-1:0] col_data,
  input  logic                 accumulate,
  input  logic                 drain_start,
  input  logic                 ub_wr_ready,
  output logic                 ub_wr_valid,
  output logic [AW-1:0]        ub_wr_addr,
  output logic [OUT_W-1:0]     ub_wr_data,
  output logic                 busy,
  output logic                 drain_done,
  output logic                 err_overrun,
  input  logic                 err_clear
);

  localparam int NENT = ROWS * COLS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] LAST_K = AW'(NENT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q [NENT];
  logic signed [ACC_W-1:0]  acc_d [NENT];
  logic [RW-1:0]            wp_q [COLS];
  logic [RW-1:0]            wp_d [COLS];
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [OUT_W-1:0]         data_q, data_d;
  logic signed [IN_W-1:0]   din;
  logic signed [ACC_W-1:0]  ext;
  logic [AW-1:0]            idx;
  logic                     accept;

  function automatic logic [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else                  return v[OUT_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    wp_d    = wp_q;
    err_d   = err_q;
    done_d  = 1'b0;
    din     = '0;
    ext     = '0;
    idx     = '0;
    accept  = valid_q & ub_wr_ready;

    if (err_clear) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        for (int c = 0; c < COLS; c++) begin
          if (col_valid[c]) begin
            din      = col_data[c*IN_W +: IN_W];
            ext      = ACC_W'(din);
            idx      = AW'(int'(wp_q[c]) * COLS + c);
            acc_d[idx] = accumulate ? acc_q[idx] + ext : ext;
            wp_d[c]  = (wp_q[c] == RW'(ROWS - 1)) ? '0 : wp_q[c] + 1'b1;
          end
        end
        if (drain_start) begin
          state_d = DRAIN;
          k_d     = '0;
        end
      end
      DRAIN: begin
        if (|col_valid) err_d = 1'b1;
        if (accept) begin
          acc_d[k_q] = '0;
          if (k_q == LAST_K) begin
            state_d = IDLE;
            k_d     = '0;
            done_d  = 1'b1;
            for (int c = 0; c < COLS; c++) wp_d[c] = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so a same-cycle write shows up in beat 0.
    valid_d = (state_d == DRAIN);
    busy_d  = (state_d == DRAIN);
    addr_d  = (state_d == DRAIN) ? k_d : '0;
    data_d  = (state_d == DRAIN) ? sat(acc_d[k_d]) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int i = 0; i < NENT; i++) acc_q[i] <= '0;
      for (int c = 0; c < COLS; c++) wp_q[c] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      wp_q    <= wp_d;
    end
  end

  assign ub_wr_valid = valid_q;
  assign ub_wr_addr  = addr_q;
  assign ub_wr_data  = data_q;
  assign busy        = busy_q;
  assign drain_done  = done_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Randomized self-checking bench for accumulator_bank, compared against a
// bank-level reference model of entries, write pointers and drain order.
module tb_accumulator_bank;

  localparam int COLS  = 2;
  localparam int ROWS  = 2;
  localparam int IN_W  = 32;
  localparam int ACC_W = 40;
  localparam int OUT_W = 32;
  localparam int AW    = 2;
  localparam int N     = ROWS * COLS;

  logic                 clk;
  logic                 reset;
  logic [COLS-1:0]      colValid;
  logic [COLS*IN_W-1:0] colData;
  logic                 accumulate;
  logic                 drainStart;
  logic                 ubWrReady;
  logic                 ubWrValid;
  logic [AW-1:0]        ubWrAddr;
  logic [OUT_W-1:0]     ubWrData;
  logic                 busy;
  logic                 drainDone;
  logic                 errOverrun;
  logic                 errClear;

  int errCount;
  int checkCount;

  longint modelMem [N];
  int     modelWp [COLS];

  accumulator_bank #(
    .COLS(COLS), .ROWS(ROWS), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_valid(colValid),
    .col_data(colData),
    .accumulate(accumulate),
    .drain_start(drainStart),
    .ub_wr_ready(ubWrReady),
    .ub_wr_valid(ubWrValid),
    .ub_wr_addr(ubWrAddr),
    .ub_wr_data(ubWrData),
    .busy(busy),
    .drain_done(drainDone),
    .err_overrun(errOverrun),
    .err_clear(errClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COLS*IN_W-1:0] pack(input logic [IN_W-1:0] c0, input logic [IN_W-1:0] c1);
    return {c1, c0};
  endfunction

  function automatic longint wrapAcc(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic logic [OUT_W-1:0] satRef(input longint v);
    longint maxV;
    longint minV;
    maxV = (longint'(1) << (OUT_W - 1)) - 1;
    minV = -(longint'(1) << (OUT_W - 1));
    if (v > maxV) return OUT_W'(maxV);
    if (v < minV) return OUT_W'(minV);
    return OUT_W'(v);
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < N; i++) modelMem[i] = 0;
    for (int c = 0; c < COLS; c++) modelWp[c] = 0;
  endfunction

  // One IDLE cycle of column writes (optionally with drain_start), mirrored into the model.
  task automatic applyStimulus(input logic [COLS-1:0] v, input logic [COLS*IN_W-1:0] d,
                               input logic acc, input logic start);
    logic signed [IN_W-1:0] s;
    int e;
    colValid   = v;
    colData    = d;
    accumulate = acc;
    drainStart = start;
    tick();
    for (int c = 0; c < COLS; c++) begin
      if (v[c]) begin
        s = d[c*IN_W +: IN_W];
        e = modelWp[c] * COLS + c;
        modelMem[e] = wrapAcc(acc ? modelMem[e] + longint'(s) : longint'(s));
        modelWp[c]  = (modelWp[c] + 1) % ROWS;
      end
    end
    colValid   = '0;
    drainStart = 1'b0;
  endtask

  task automatic writeTest1(input logic acc);
    applyStimulus(2'b01, pack(81, 0), acc, 1'b0);
    applyStimulus(2'b11, pack(151, 127), acc, 1'b0);
    applyStimulus(2'b10, pack(0, 237), acc, 1'b0);
  endtask

  // mode 0: ready high, 1: fixed stall pattern, 2: random ready plus stray drain_start.
  task automatic drainAndCheck(input int mode, input bit overrun,
                               input logic [COLS-1:0] sv, input logic [COLS*IN_W-1:0] sd,
                               input logic sacc);
    logic [OUT_W-1:0] expQ [N];
    logic [6:0] pat;
    logic r;
    int k;
    int cycles;
    pat = 7'b1101001;
    applyStimulus(sv, sd, sacc, 1'b1);
    for (int i = 0; i < N; i++) expQ[i] = satRef(modelMem[i]);
    clearModel();
    k = 0;
    cycles = 0;
    while (k < N && cycles < 200) begin
      checkOutput("drainBusy", busy, 1);
      checkOutput("drainValid", ubWrValid, 1);
      checkOutput("drainAddr", ubWrAddr, k);
      checkOutput("drainData", ubWrData, expQ[k]);
      if (overrun && cycles == 1) begin
        colValid = 2'b10;
        colData  = pack(0, 999);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cycles < 7) ? pat[cycles] : 1'b1;
        default: begin
          r = 1'($urandom_range(0, 1));
          drainStart = 1'($urandom_range(0, 1));
        end
      endcase
      ubWrReady = r;
      tick();
      colValid   = '0;
      drainStart = 1'b0;
      if (r) k++;
      cycles++;
    end
    if (k < N) checkOutput("drainTimeout", k, N);
    ubWrReady = 1'b0;
    checkOutput("doneHigh", drainDone, 1);
    checkOutput("busyAfter", busy, 0);
    checkOutput("validAfter", ubWrValid, 0);
    if (mode == 0) checkOutput("drainCycles", cycles, N);
    if (mode == 1) checkOutput("stallCycles", cycles, 7);
    if (overrun) checkOutput("errOverrunSet", errOverrun, 1);
    tick();
    checkOutput("doneLow", drainDone, 0);
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    reset      = 1'b0;
    colValid   = '0;
    colData    = '0;
    accumulate = 1'b0;
    drainStart = 1'b0;
    ubWrReady  = 1'b0;
    errClear   = 1'b0;
    clearModel();
    #3;
    checkOutput("rstValid", ubWrValid, 0);
    checkOutput("rstAddr", ubWrAddr, 0);
    checkOutput("rstData", ubWrData, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", drainDone, 0);
    checkOutput("rstErr", errOverrun, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] overwrite drain");
    writeTest1(1'b0);
    drainAndCheck(0, 1'b0, '0, '0, 1'b0);

    $display("[TB] accumulate drain");
    writeTest1(1'b0);
    writeTest1(1'b1);
    drainAndCheck(0, 1'b0, '0, '0, 1'b0);

    $display("[TB] backpressure drain");
    writeTest1(1'b0);
    drainAndCheck(1, 1'b0, '0, '0, 1'b0);

    $display("[TB] saturation");
    applyStimulus(2'b11, pack(32'h7FFFFFFF, 32'h80000000), 1'b0, 1'b0);
    applyStimulus(2'b11, pack(-5, 0), 1'b0, 1'b0);
    applyStimulus(2'b11, pack(1, -1), 1'b1, 1'b0);
    applyStimulus(2'b11, pack(0, 0), 1'b1, 1'b0);
    drainAndCheck(0, 1'b0, '0, '0, 1'b0);

    $display("[TB] overrun");
    writeTest1(1'b0);
    drainAndCheck(0, 1'b1, '0, '0, 1'b0);
    checkOutput("errPersist", errOverrun, 1);
    errClear = 1'b1;
    tick();
    errClear = 1'b0;
    checkOutput("errCleared", errOverrun, 0);
    drainAndCheck(0, 1'b0, '0, '0, 1'b0);

    $display("[TB] reset mid-drain");
    writeTest1(1'b0);
    applyStimulus('0, '0, 1'b0, 1'b1);
    ubWrReady = 1'b1;
    tick();
    tick();
    checkOutput("preResetAddr", ubWrAddr, 2);
    reset = 1'b0;
    #1;
    checkOutput("asyncValid", ubWrValid, 0);
    checkOutput("asyncAddr", ubWrAddr, 0);
    checkOutput("asyncData", ubWrData, 0);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncDone", drainDone, 0);
    tick();
    checkOutput("inResetDone", drainDone, 0);
    reset = 1'b1;
    ubWrReady = 1'b0;
    clearModel();
    tick();
    checkOutput("postResetDone", drainDone, 0);
    checkOutput("postResetBusy", busy, 0);
    drainAndCheck(0, 1'b0, '0, '0, 1'b0);

    $display("[TB] randomized rounds");
    for (int round = 0; round < 8; round++) begin
      int nWrites;
      nWrites = $urandom_range(1, 8);
      for (int w = 0; w < nWrites; w++) begin
        applyStimulus(COLS'($urandom_range(0, 3)), pack($urandom, $urandom),
                      1'($urandom_range(0, 1)), 1'b0);
      end
      drainAndCheck(2, 1'b0, COLS'($urandom_range(0, 3)), pack($urandom, $urandom),
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
